// File: rtl/vc_input_buffer.sv
// vc_input_buffer: per-port input stage that steers words into two
// show-ahead virtual-channel FIFOs and presents their heads to the VC arbiter.
module vc_input_buffer #(
   parameter int unsigned DATA_WIDTH = 5,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_W     = 2,
   parameter int unsigned AF_THRESH  = 3
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  push,
   input  logic                  vcId,
   input  logic [DATA_WIDTH-1:0] dataIn,
   input  logic                  validIn,
   input  logic                  popVC0,
   input  logic                  popVC1,
   output logic [DATA_WIDTH-1:0] VC0_out,
   output logic [DATA_WIDTH-1:0] VC1_out,
   output logic [1:0]            validBits,
   output logic                  emptyVC0,
   output logic                  emptyVC1,
   output logic                  fullVC0,
   output logic                  fullVC1,
   output logic                  almostFullVC0,
   output logic                  almostFullVC1,
   output logic                  pause,
   output logic                  errOverflow
);

   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam int unsigned WORD_W = DATA_WIDTH + 1;
   localparam int unsigned NUM_VC = 2;

   logic [NUM_VC-1:0]                 w_pop_req;
   logic [NUM_VC-1:0]                 w_empty;
   logic [NUM_VC-1:0]                 w_full;
   logic [NUM_VC-1:0]                 w_af;
   logic [NUM_VC-1:0]                 w_head_valid;
   logic [NUM_VC-1:0]                 w_drop;
   logic [NUM_VC-1:0][DATA_WIDTH-1:0] w_head_data;
   logic                              r_err;

   assign w_pop_req = {popVC1, popVC0};

   for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
      logic [WORD_W-1:0] r_mem [DEPTH];
      logic [ADDR_W-1:0] r_rd_ptr;
      logic [ADDR_W-1:0] r_wr_ptr;
      logic [CNT_W-1:0]  r_count;
      logic              w_sel;
      logic              w_pop;
      logic              w_wr;
      logic [WORD_W-1:0] w_head;

      // A pop on this VC frees a slot in the same cycle, so a full FIFO can still accept
      assign w_sel          = push && (vcId == 1'(g));
      assign w_empty[g]     = (r_count == '0);
      assign w_full[g]      = (r_count == CNT_W'(DEPTH));
      assign w_af[g]        = (r_count >= CNT_W'(AF_THRESH));
      assign w_pop          = w_pop_req[g] && !w_empty[g];
      assign w_wr           = w_sel && (!w_full[g] || w_pop);
      assign w_drop[g]      = w_sel && w_full[g] && !w_pop;
      assign w_head         = r_mem[r_rd_ptr];
      assign w_head_data[g] = w_empty[g] ? '0 : w_head[DATA_WIDTH-1:0];
      assign w_head_valid[g] = !w_empty[g] && w_head[DATA_WIDTH];

      // Pointer and occupancy update; reset discards contents immediately
      always_ff @(posedge clk or negedge reset_L) begin
         if (!reset_L) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_wr) begin
               r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            if (w_wr && !w_pop) begin
               r_count <= r_count + CNT_W'(1);
            end else if (!w_wr && w_pop) begin
               r_count <= r_count - CNT_W'(1);
            end
         end
      end

      // Storage array, intentionally left uninitialised by reset
      always_ff @(posedge clk) begin
         if (w_wr) begin
            r_mem[r_wr_ptr] <= {validIn, dataIn};
         end
      end
   end

   // Sticky overflow flag for any dropped push
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_err <= 1'b0;
      end else if (|w_drop) begin
         r_err <= 1'b1;
      end
   end

   assign VC0_out       = w_head_data[0];
   assign VC1_out       = w_head_data[1];
   assign validBits     = w_head_valid;
   assign emptyVC0      = w_empty[0];
   assign emptyVC1      = w_empty[1];
   assign fullVC0       = w_full[0];
   assign fullVC1       = w_full[1];
   assign almostFullVC0 = w_af[0];
   assign almostFullVC1 = w_af[1];
   assign pause         = |w_af;
   assign errOverflow   = r_err;

endmodule

// File: tb/tb_vc_input_buffer.sv
// tb_vc_input_buffer: directed table, corner sequences and random traffic
// checked against a queue-based model of the two VC FIFOs.
module tb_vc_input_buffer;

   localparam int DW    = 5;
   localparam int DEPTH = 4;
   localparam int AF    = 3;

   typedef logic [DW:0] word_t;

   typedef struct {
      logic          pu;
      logic          vc;
      logic [DW-1:0] d;
      logic          vi;
      logic          p0;
      logic          p1;
      logic [DW-1:0] x0;
      logic [DW-1:0] x1;
      logic [1:0]    xvb;
      logic [1:0]    xemp;
      logic [1:0]    xfull;
      logic [1:0]    xaf;
      logic          xp;
      logic          xe;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset_L = 1'b0;
   logic          push = 1'b0;
   logic          vcId = 1'b0;
   logic [DW-1:0] dataIn = '0;
   logic          validIn = 1'b0;
   logic          popVC0 = 1'b0;
   logic          popVC1 = 1'b0;
   logic [DW-1:0] VC0_out;
   logic [DW-1:0] VC1_out;
   logic [1:0]    validBits;
   logic          emptyVC0, emptyVC1, fullVC0, fullVC1;
   logic          almostFullVC0, almostFullVC1, pause, errOverflow;

   int    n_vec = 0;
   int    n_err = 0;
   word_t mq0[$];
   word_t mq1[$];
   logic  m_err = 1'b0;
   vec_t  tbl [14];

   always #5 clk = ~clk;

   vc_input_buffer dut (
      .clk(clk), .reset_L(reset_L), .push(push), .vcId(vcId),
      .dataIn(dataIn), .validIn(validIn), .popVC0(popVC0), .popVC1(popVC1),
      .VC0_out(VC0_out), .VC1_out(VC1_out), .validBits(validBits),
      .emptyVC0(emptyVC0), .emptyVC1(emptyVC1),
      .fullVC0(fullVC0), .fullVC1(fullVC1),
      .almostFullVC0(almostFullVC0), .almostFullVC1(almostFullVC1),
      .pause(pause), .errOverflow(errOverflow)
   );

   task automatic cmp(input string nm, input string fld, input int got, input int exp);
      if (got != exp) begin
         n_err++;
         $display("FAIL %s %s: got %0h expected %0h", nm, fld, got, exp);
      end
   endtask

   task automatic check(input string nm, input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                        input logic [1:0] xvb, input logic [1:0] xemp, input logic [1:0] xfull,
                        input logic [1:0] xaf, input logic xp, input logic xe);
      n_vec++;
      cmp(nm, "VC0_out", int'(VC0_out), int'(x0));
      cmp(nm, "VC1_out", int'(VC1_out), int'(x1));
      cmp(nm, "validBits", int'(validBits), int'(xvb));
      cmp(nm, "empty", int'({emptyVC1, emptyVC0}), int'(xemp));
      cmp(nm, "full", int'({fullVC1, fullVC0}), int'(xfull));
      cmp(nm, "almostFull", int'({almostFullVC1, almostFullVC0}), int'(xaf));
      cmp(nm, "pause", int'(pause), int'(xp));
      cmp(nm, "errOverflow", int'(errOverflow), int'(xe));
   endtask

   // Expected outputs derived from the model queues
   task automatic check_model(input string nm);
      word_t         h;
      logic [DW-1:0] x0, x1;
      logic [1:0]    vb, emp, full, af;
      x0 = '0; x1 = '0; vb = '0;
      if (mq0.size() != 0) begin h = mq0[0]; x0 = h[DW-1:0]; vb[0] = h[DW]; end
      if (mq1.size() != 0) begin h = mq1[0]; x1 = h[DW-1:0]; vb[1] = h[DW]; end
      emp  = {mq1.size() == 0, mq0.size() == 0};
      full = {mq1.size() == DEPTH, mq0.size() == DEPTH};
      af   = {mq1.size() >= AF, mq0.size() >= AF};
      check(nm, x0, x1, vb, emp, full, af, |af, m_err);
   endtask

   // Pop first (frees a slot), then push if room, else flag overflow
   task automatic model_step(input logic pu, input logic vc, input logic [DW-1:0] d,
                             input logic vi, input logic p0, input logic p1);
      word_t tmp;
      if (p0 && mq0.size() != 0) tmp = mq0.pop_front();
      if (p1 && mq1.size() != 0) tmp = mq1.pop_front();
      if (pu && !vc) begin
         if (mq0.size() < DEPTH) mq0.push_back({vi, d}); else m_err = 1'b1;
      end
      if (pu && vc) begin
         if (mq1.size() < DEPTH) mq1.push_back({vi, d}); else m_err = 1'b1;
      end
   endtask

   task automatic cycle(input logic pu, input logic vc, input logic [DW-1:0] d,
                        input logic vi, input logic p0, input logic p1);
      push = pu; vcId = vc; dataIn = d; validIn = vi; popVC0 = p0; popVC1 = p1;
      @(posedge clk);
      #1;
      model_step(pu, vc, d, vi, p0, p1);
      push = 1'b0; popVC0 = 1'b0; popVC1 = 1'b0;
   endtask

   task automatic do_reset();
      push = 1'b0; popVC0 = 1'b0; popVC1 = 1'b0;
      reset_L = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_L = 1'b1;
      mq0.delete(); mq1.delete(); m_err = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{1'b1,1'b0,5'b10010,1'b1,1'b0,1'b0, 5'b10010,5'b00000,2'b01,2'b10,2'b00,2'b00,1'b0,1'b0};
      tbl[1]  = '{1'b0,1'b0,5'b00000,1'b0,1'b1,1'b0, 5'b00000,5'b00000,2'b00,2'b11,2'b00,2'b00,1'b0,1'b0};
      tbl[2]  = '{1'b1,1'b1,5'b01011,1'b1,1'b0,1'b0, 5'b00000,5'b01011,2'b10,2'b01,2'b00,2'b00,1'b0,1'b0};
      tbl[3]  = '{1'b1,1'b1,5'b11001,1'b0,1'b0,1'b0, 5'b00000,5'b01011,2'b10,2'b01,2'b00,2'b00,1'b0,1'b0};
      tbl[4]  = '{1'b1,1'b1,5'b01101,1'b1,1'b0,1'b0, 5'b00000,5'b01011,2'b10,2'b01,2'b00,2'b10,1'b1,1'b0};
      tbl[5]  = '{1'b1,1'b1,5'b11111,1'b1,1'b0,1'b0, 5'b00000,5'b01011,2'b10,2'b01,2'b10,2'b10,1'b1,1'b0};
      tbl[6]  = '{1'b1,1'b1,5'b00001,1'b1,1'b0,1'b0, 5'b00000,5'b01011,2'b10,2'b01,2'b10,2'b10,1'b1,1'b1};
      tbl[7]  = '{1'b0,1'b0,5'b00000,1'b0,1'b0,1'b1, 5'b00000,5'b11001,2'b00,2'b01,2'b00,2'b10,1'b1,1'b1};
      tbl[8]  = '{1'b0,1'b0,5'b00000,1'b0,1'b0,1'b1, 5'b00000,5'b01101,2'b10,2'b01,2'b00,2'b00,1'b0,1'b1};
      tbl[9]  = '{1'b0,1'b0,5'b00000,1'b0,1'b0,1'b1, 5'b00000,5'b11111,2'b10,2'b01,2'b00,2'b00,1'b0,1'b1};
      tbl[10] = '{1'b0,1'b0,5'b00000,1'b0,1'b0,1'b1, 5'b00000,5'b00000,2'b00,2'b11,2'b00,2'b00,1'b0,1'b1};
      tbl[11] = '{1'b0,1'b0,5'b00000,1'b0,1'b0,1'b1, 5'b00000,5'b00000,2'b00,2'b11,2'b00,2'b00,1'b0,1'b1};
      tbl[12] = '{1'b1,1'b0,5'b00111,1'b1,1'b1,1'b0, 5'b00111,5'b00000,2'b01,2'b10,2'b00,2'b00,1'b0,1'b1};
      tbl[13] = '{1'b1,1'b1,5'b10101,1'b1,1'b1,1'b0, 5'b00000,5'b10101,2'b10,2'b01,2'b00,2'b00,1'b0,1'b1};

      // Reset then idle
      do_reset();
      check("reset_idle", 5'b0, 5'b0, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);

      // Directed table: single word, fill/overflow/drain of VC1, pop-on-empty
      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].pu, tbl[i].vc, tbl[i].d, tbl[i].vi, tbl[i].p0, tbl[i].p1);
         check($sformatf("tbl%0d", i), tbl[i].x0, tbl[i].x1, tbl[i].xvb, tbl[i].xemp,
               tbl[i].xfull, tbl[i].xaf, tbl[i].xp, tbl[i].xe);
      end

      // Full VC0 with simultaneous push and pop
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, 5'(i + 16), 1'b1, 1'b0, 1'b0);
         check_model($sformatf("fill0_%0d", i));
      end
      cycle(1'b1, 1'b0, 5'b00100, 1'b1, 1'b1, 1'b0);
      check_model("full_pushpop");
      n_vec++;
      cmp("full_pushpop_const", "full0/err/head", int'({fullVC0, errOverflow, VC0_out}),
          int'({1'b1, 1'b0, 5'd17}));
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            n_vec++;
            cmp("last_out", "VC0_out", int'(VC0_out), int'(5'b00100));
         end
         cycle(1'b0, 1'b0, 5'b0, 1'b0, 1'b1, 1'b0);
         check_model($sformatf("drain0_%0d", i));
      end

      // Independence and pointer wrap: VC0 streams 1..10, VC1 gets three words
      do_reset();
      begin
         int nxt;
         int v1;
         nxt = 1; v1 = 0;
         for (int k = 0; k < 13; k++) begin
            if (k % 4 == 3 && v1 < 3) begin
               cycle(1'b1, 1'b1, 5'(20 + v1), 1'b1, 1'b1, 1'b0);
               v1++;
            end else begin
               cycle(1'b1, 1'b0, 5'(nxt), 1'b1, 1'b1, 1'b0);
               nxt++;
            end
            check_model($sformatf("wrap_%0d", k));
         end
         cycle(1'b0, 1'b0, 5'b0, 1'b0, 1'b1, 1'b0);
         check_model("wrap_tail");
         n_vec++;
         cmp("wrap_af1", "almostFullVC1", int'(almostFullVC1), 1);
      end

      // Asynchronous reset between edges with both FIFOs holding words
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 5'(i + 1), 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 5'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 5'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 5'b01010, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 5'b00110, 1'b1, 1'b0, 1'b0);
      check_model("pre_async");
      #3;
      reset_L = 1'b0;
      #1;
      mq0.delete(); mq1.delete(); m_err = 1'b0;
      check("async_reset", 5'b0, 5'b0, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset_L = 1'b1;
      check_model("post_async");

      // Random traffic with alternating pop pressure
      do_reset();
      for (int k = 0; k < 600; k++) begin
         logic rpu, rvc, rvi, rp0, rp1;
         logic [DW-1:0] rd;
         int pp;
         pp  = ((k / 50) % 2 == 0) ? 20 : 70;
         rpu = ($urandom_range(0, 99) < 65);
         rvc = 1'($urandom);
         rvi = ($urandom_range(0, 99) < 80);
         rd  = 5'($urandom);
         rp0 = ($urandom_range(0, 99) < 32'(pp));
         rp1 = ($urandom_range(0, 99) < 32'(pp));
         cycle(rpu, rvc, rd, rvi, rp0, rp1);
         check_model($sformatf("rand_%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
